// File: rtl/mem_router.sv
// Registered CPU-to-memory router: RAM, text RAM, BIOS, banked A0000 window, per-region wait states.
// Define MEM_ROUTER_BIOS_WP_EN to write-protect the BIOS (writes still complete, bios_we stays low).
//
// state | meaning
// IDLE  | waiting for cpu_req; decode and latch the request
// WAIT  | counting down region latency; write pulse lands in the first cycle
// DONE  | capture read data, raise cpu_ready on the way back to IDLE
module mem_router #(
  parameter int          ADDR_W    = 32,
  parameter int          RAM_BITS  = 18,
  parameter logic [19:0] TEXT_BASE = 20'hB8000,
  parameter int          TEXT_BITS = 13,
  parameter logic [19:0] BIOS_BASE = 20'hF8000,
  parameter int          BIOS_BITS = 15,
  parameter int          BANK_W    = 2,
  parameter int          WAIT_RAM  = 1,
  parameter int          WAIT_TEXT = 1,
  parameter int          WAIT_BIOS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    cpu_address,
  input  logic [7:0]           cpu_out,
  input  logic                 cpu_we,
  input  logic                 cpu_req,
  output logic [7:0]           cpu_in,
  output logic                 cpu_ready,
  input  logic [1:0]           videomode,
  input  logic                 bank_we,
  input  logic [BANK_W-1:0]    bank_data,
  output logic [RAM_BITS-1:0]  ram_address,
  output logic                 ram_we,
  input  logic [7:0]           ram_q,
  output logic [TEXT_BITS-1:0] text_address,
  output logic                 text_we,
  input  logic [7:0]           text_q,
  output logic [BIOS_BITS-1:0] bios_address,
  output logic                 bios_we,
  input  logic [7:0]           bios_q,
  output logic [7:0]           mem_data,
  output logic [BANK_W-1:0]    bank
);

`ifdef MEM_ROUTER_BIOS_WP_EN
  localparam logic BIOS_WR_OK = 1'b0;
`else
  localparam logic BIOS_WR_OK = 1'b1;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [2:0] {RG_RAM, RG_TEXT, RG_WIN, RG_BIOS, RG_NONE} region_t;

  state_t              state, state_next;
  region_t             region, req_region;
  logic                is_write;
  logic [7:0]          cnt, cnt_next, req_lat;
  logic [19:0]         addr20;
  logic [RAM_BITS-1:0] win_addr;
  logic                accept, finish;
  logic                unused_addr_hi;

  // Address bits above 19 are ignored: the CPU space wraps at 1M.
  assign addr20         = cpu_address[19:0];
  assign unused_addr_hi = ^cpu_address[ADDR_W-1:20];

  always_comb begin
    req_region = RG_NONE;
    if ((addr20 >> RAM_BITS) == 20'd0)
      req_region = RG_RAM;
    else if (addr20[19:TEXT_BITS] == TEXT_BASE[19:TEXT_BITS])
      req_region = RG_TEXT;
    else if (addr20[19:16] == 4'hA && videomode == 2'd2)
      req_region = RG_WIN;
    else if (addr20[19:BIOS_BITS] == BIOS_BASE[19:BIOS_BITS])
      req_region = RG_BIOS;
  end

  always_comb begin
    req_lat = 8'd0;
    if (!cpu_we) begin
      case (req_region)
        RG_RAM, RG_WIN: req_lat = 8'(WAIT_RAM);
        RG_TEXT:        req_lat = 8'(WAIT_TEXT);
        RG_BIOS:        req_lat = 8'(WAIT_BIOS);
        default:        req_lat = 8'd0;
      endcase
    end
  end

  // Window bits above the bank field read as ones so the window lands in the top of RAM.
  always_comb begin
    win_addr = '1;
    win_addr[BANK_W+15:0] = {bank, addr20[15:0]};
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          accept     = 1'b1;
          cnt_next   = req_lat;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 8'd0) state_next = ST_DONE;
        else             cnt_next   = cnt - 8'd1;
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      region       <= RG_NONE;
      is_write     <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_in       <= 8'hFF;
      ram_we       <= 1'b0;
      text_we      <= 1'b0;
      bios_we      <= 1'b0;
      ram_address  <= '0;
      text_address <= '0;
      bios_address <= '0;
      mem_data     <= 8'd0;
      bank         <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cpu_ready <= finish;
      ram_we    <= 1'b0;
      text_we   <= 1'b0;
      bios_we   <= 1'b0;
      if (bank_we) bank <= bank_data;
      if (accept) begin
        region   <= req_region;
        is_write <= cpu_we;
        mem_data <= cpu_out;
        case (req_region)
          RG_RAM: begin
            ram_address <= addr20[RAM_BITS-1:0];
            ram_we      <= cpu_we;
          end
          RG_WIN: begin
            ram_address <= win_addr;
            ram_we      <= cpu_we;
          end
          RG_TEXT: begin
            text_address <= addr20[TEXT_BITS-1:0];
            text_we      <= cpu_we;
          end
          RG_BIOS: begin
            bios_address <= addr20[BIOS_BITS-1:0];
            bios_we      <= cpu_we & BIOS_WR_OK;
          end
          default: ;
        endcase
      end
      if (finish && !is_write) begin
        case (region)
          RG_RAM, RG_WIN: cpu_in <= ram_q;
          RG_TEXT:        cpu_in <= text_q;
          RG_BIOS:        cpu_in <= bios_q;
          default:        cpu_in <= 8'hFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: vector table of single accesses plus hand sequences
// for bank change in flight, busy requests and reset mid-access.
module tb_mem_router;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_address = 32'd0;
  logic [7:0]  cpu_out = 8'd0;
  logic        cpu_we = 1'b0;
  logic        cpu_req = 1'b0;
  logic [7:0]  cpu_in;
  logic        cpu_ready;
  logic [1:0]  videomode = 2'd2;
  logic        bank_we = 1'b0;
  logic [1:0]  bank_data = 2'd0;
  logic [17:0] ram_address;
  logic        ram_we;
  logic [7:0]  ram_q = 8'd0;
  logic [12:0] text_address;
  logic        text_we;
  logic [7:0]  text_q = 8'd0;
  logic [14:0] bios_address;
  logic        bios_we;
  logic [7:0]  bios_q = 8'd0;
  logic [7:0]  mem_data;
  logic [1:0]  bank;

  int errors = 0;
  int checks = 0;

  mem_router dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_req(cpu_req),
    .cpu_in(cpu_in), .cpu_ready(cpu_ready), .videomode(videomode),
    .bank_we(bank_we), .bank_data(bank_data),
    .ram_address(ram_address), .ram_we(ram_we), .ram_q(ram_q),
    .text_address(text_address), .text_we(text_we), .text_q(text_q),
    .bios_address(bios_address), .bios_we(bios_we), .bios_q(bios_q),
    .mem_data(mem_data), .bank(bank)
  );

  always #5 clock = ~clock;

  // Synchronous one-cycle-read memories behind the router.
  logic [7:0] ram_mem  [0:(1<<18)-1];
  logic [7:0] text_mem [0:(1<<13)-1];
  logic [7:0] bios_mem [0:(1<<15)-1];

  always @(posedge clock) begin
    if (ram_we)  ram_mem[ram_address]   <= mem_data;
    if (text_we) text_mem[text_address] <= mem_data;
    if (bios_we) bios_mem[bios_address] <= mem_data;
    ram_q  <= ram_mem[ram_address];
    text_q <= text_mem[text_address];
    bios_q <= bios_mem[bios_address];
  end

`ifdef MEM_ROUTER_BIOS_WP_EN
  localparam logic [2:0] BIOS_WEM = 3'b000;
  localparam logic [7:0] BIOS_RD  = 8'h11;
`else
  localparam logic [2:0] BIOS_WEM = 3'b100;
  localparam logic [7:0] BIOS_RD  = 8'hA5;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [1:0]  vm;
    int          lat;
    logic        chk_rd;
    logic [7:0]  rd;
    logic [2:0]  wem;
    logic [19:0] wa;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic w, input logic [7:0] d,
                           input logic [1:0] vm);
    @(negedge clock);
    cpu_address = a; cpu_we = w; cpu_out = d; videomode = vm; cpu_req = 1'b1;
    @(negedge clock);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // i counts clock edges after the one that sampled the request.
  task automatic watch(input int i0, output int lat, output logic [2:0] wem, output int wecnt,
                       output logic [19:0] wa, output logic [7:0] rd, output logic ovl,
                       output logic rdy_after);
    lat = -1; wem = 3'b000; wecnt = 0; wa = 20'd0; rd = 8'd0; ovl = 1'b0; rdy_after = 1'b0;
    for (int i = i0; i < i0 + 20; i++) begin
      if (ram_we || text_we || bios_we) begin
        wecnt++;
        wem = wem | {bios_we, text_we, ram_we};
        if (ram_we)  wa = 20'(ram_address);
        if (text_we) wa = 20'(text_address);
        if (bios_we) wa = 20'(bios_address);
      end
      if (cpu_ready) begin
        if (ram_we || text_we || bios_we) ovl = 1'b1;
        lat = i;
        rd  = cpu_in;
        @(negedge clock);
        rdy_after = cpu_ready;
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int          lat, wecnt, nrdy;
    logic [2:0]  wem;
    logic [19:0] wa;
    logic [7:0]  rd;
    logic        ovl, rdy_after;
    string       nm;

    for (int i = 0; i < (1<<18); i++) ram_mem[i] = 8'h00;
    for (int i = 0; i < (1<<13); i++) text_mem[i] = 8'h00;
    for (int i = 0; i < (1<<15); i++) bios_mem[i] = 8'h00;
    bios_mem[15'h7FF0] = 8'h9E;
    bios_mem[15'h0000] = 8'h11;

    //           addr          we    wd     vm    lat chk   rd     wem       wa
    vecs[0]  = '{32'h00001234, 1'b1, 8'h5A, 2'd2, 2, 1'b0, 8'h00, 3'b001,   20'h01234};
    vecs[1]  = '{32'h00001234, 1'b0, 8'h00, 2'd2, 3, 1'b1, 8'h5A, 3'b000,   20'h00000};
    vecs[2]  = '{32'h000A0010, 1'b1, 8'hC3, 2'd2, 2, 1'b0, 8'h00, 3'b001,   20'h30010};
    vecs[3]  = '{32'h000A0010, 1'b0, 8'h00, 2'd2, 3, 1'b1, 8'hC3, 3'b000,   20'h00000};
    vecs[4]  = '{32'h000A0010, 1'b1, 8'h77, 2'd0, 2, 1'b0, 8'h00, 3'b000,   20'h00000};
    vecs[5]  = '{32'h000A0010, 1'b0, 8'h00, 2'd0, 2, 1'b1, 8'hFF, 3'b000,   20'h00000};
    vecs[6]  = '{32'h00030010, 1'b0, 8'h00, 2'd0, 3, 1'b1, 8'hC3, 3'b000,   20'h00000};
    vecs[7]  = '{32'h000B8002, 1'b1, 8'h41, 2'd2, 2, 1'b0, 8'h00, 3'b010,   20'h00002};
    vecs[8]  = '{32'h000B8002, 1'b0, 8'h00, 2'd2, 3, 1'b1, 8'h41, 3'b000,   20'h00000};
    vecs[9]  = '{32'h000F8000, 1'b1, 8'hA5, 2'd2, 2, 1'b0, 8'h00, BIOS_WEM, 20'h00000};
    vecs[10] = '{32'h000F8000, 1'b0, 8'h00, 2'd2, 3, 1'b1, BIOS_RD, 3'b000, 20'h00000};
    vecs[11] = '{32'h000C0000, 1'b0, 8'h00, 2'd2, 2, 1'b1, 8'hFF, 3'b000,   20'h00000};
    vecs[12] = '{32'h000C0000, 1'b1, 8'h99, 2'd2, 2, 1'b0, 8'h00, 3'b000,   20'h00000};
    vecs[13] = '{32'h00101234, 1'b0, 8'h00, 2'd2, 3, 1'b1, 8'h5A, 3'b000,   20'h00000};
    vecs[14] = '{32'h000BA000, 1'b0, 8'h00, 2'd2, 2, 1'b1, 8'hFF, 3'b000,   20'h00000};
    vecs[15] = '{32'h00040000, 1'b0, 8'h00, 2'd2, 2, 1'b1, 8'hFF, 3'b000,   20'h00000};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_cpu_in", 32'(cpu_in), 32'hFF);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_we", 32'({bios_we, text_we, ram_we}), 32'h0);
    chk("rst_bank", 32'(bank), 32'h0);
    chk("rst_addr", 32'({ram_address, text_address, bios_address}), 32'h0);
    chk("rst_mem_data", 32'(mem_data), 32'h0);

    bank_we = 1'b1; bank_data = 2'd3;
    @(negedge clock);
    bank_we = 1'b0;
    chk("bank_load", 32'(bank), 32'h3);

    for (int k = 0; k < 16; k++) begin
      start_req(vecs[k].addr, vecs[k].we, vecs[k].wd, vecs[k].vm);
      watch(0, lat, wem, wecnt, wa, rd, ovl, rdy_after);
      nm = $sformatf("v%0d", k);
      chk({nm, "_lat"}, 32'(lat), 32'(vecs[k].lat));
      chk({nm, "_we_mask"}, 32'(wem), 32'(vecs[k].wem));
      chk({nm, "_we_cycles"}, 32'(wecnt), (vecs[k].wem != 3'b000) ? 32'd1 : 32'd0);
      chk({nm, "_ready_we_overlap"}, 32'(ovl), 32'h0);
      chk({nm, "_ready_width"}, 32'(rdy_after), 32'h0);
      if (vecs[k].wem != 3'b000) chk({nm, "_we_addr"}, 32'(wa), 32'(vecs[k].wa));
      if (vecs[k].we) chk({nm, "_mem_data"}, 32'(mem_data), 32'(vecs[k].wd));
      if (vecs[k].chk_rd) chk({nm, "_rd"}, 32'(rd), 32'(vecs[k].rd));
    end

    // BIOS top-of-ROM read and its address mapping.
    start_req(32'h000FFFF0, 1'b0, 8'h00, 2'd2);
    watch(0, lat, wem, wecnt, wa, rd, ovl, rdy_after);
    chk("bios_top_lat", 32'(lat), 32'd3);
    chk("bios_top_addr", 32'(bios_address), 32'h7FF0);
    chk("bios_top_rd", 32'(rd), 32'h9E);

    // Bank changes while a window read is in flight: the latched address holds.
    start_req(32'h000A0010, 1'b0, 8'h00, 2'd2);
    bank_we = 1'b1; bank_data = 2'd1;
    @(negedge clock);
    bank_we = 1'b0;
    watch(1, lat, wem, wecnt, wa, rd, ovl, rdy_after);
    chk("bank_flight_lat", 32'(lat), 32'd3);
    chk("bank_flight_addr", 32'(ram_address), 32'h30010);
    chk("bank_flight_rd", 32'(rd), 32'hC3);
    chk("bank_flight_bank", 32'(bank), 32'h1);

    // New bank applies to the next window write.
    start_req(32'h000A0020, 1'b1, 8'h3C, 2'd2);
    watch(0, lat, wem, wecnt, wa, rd, ovl, rdy_after);
    chk("bank1_we_addr", 32'(wa), 32'h10020);

    // Request while busy is dropped: one completion with the first request's data.
    start_req(32'h00001234, 1'b0, 8'h00, 2'd2);
    cpu_address = 32'h000B8002; cpu_req = 1'b1;
    @(negedge clock);
    cpu_req = 1'b0;
    watch(1, lat, wem, wecnt, wa, rd, ovl, rdy_after);
    chk("busy_lat", 32'(lat), 32'd3);
    chk("busy_rd", 32'(rd), 32'h5A);
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (cpu_ready) nrdy++;
    end
    chk("busy_extra_ready", 32'(nrdy), 32'd0);

    // Reset while a read is waiting: no completion, outputs back to reset values.
    start_req(32'h00001234, 1'b0, 8'h00, 2'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ready) nrdy++;
      @(negedge clock);
    end
    chk("rst_mid_ready", 32'(nrdy), 32'd0);
    chk("rst_mid_cpu_in", 32'(cpu_in), 32'hFF);
    chk("rst_mid_bank", 32'(bank), 32'h0);
    chk("rst_mid_we", 32'({bios_we, text_we, ram_we}), 32'h0);

    // Reset while a write pulse is high clears it on the same edge.
    @(negedge clock);
    cpu_address = 32'h00002000; cpu_we = 1'b1; cpu_out = 8'h66; cpu_req = 1'b1;
    @(negedge clock);
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_pulse_before_rst", 32'(ram_we), 32'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("wr_pulse_rst_clear", 32'(ram_we), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    start_req(32'h00001234, 1'b0, 8'h00, 2'd2);
    watch(0, lat, wem, wecnt, wa, rd, ovl, rdy_after);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rd", 32'(rd), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
Parametrised, registered memory router between the 32-bit byte-wide CPU bus and on-chip memories: low RAM, text/font RAM, BIOS ROM/RAM, plus a banked 64K graphics window.
Generalises the fixed combinational decode with:
- per-region wait states
- a request/ready handshake
- a bank register selecting which 64K of low RAM appears at A0000
- defined unmapped-access behaviour
Sits between `core` and the memory instances in the board top level; all on one clock.

Parameters:
ADDR_W, 32, CPU address width
RAM_BITS, 18, low RAM size = 2^RAM_BITS bytes, mapped at 0
TEXT_BASE, 20'hB8000, text/font RAM base
TEXT_BITS, 13, text RAM size = 2^TEXT_BITS bytes
BIOS_BASE, 20'hF8000, BIOS base
BIOS_BITS, 15, BIOS size = 2^BIOS_BITS bytes
BANK_W, 2, bank register width; window maps to RAM bytes {bank, addr[15:0]}; requires BANK_W+16 <= RAM_BITS
WAIT_RAM, 1, read latency cycles, low RAM and window
WAIT_TEXT, 1, read latency cycles, text RAM
WAIT_BIOS, 1, read latency cycles, BIOS

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_address  in  ADDR_W  byte address
cpu_out  in  8  write data
cpu_we  in  1  write qualifier, sampled with cpu_req
cpu_req  in  1  one-cycle request strobe
cpu_in  out  8  read data, held until next completion
cpu_ready  out  1  one-cycle completion pulse
videomode  in  2  window enabled only when videomode==2
bank_we  in  1  load bank register
bank_data  in  BANK_W  new bank value
ram_address  out  RAM_BITS  low RAM address
ram_we  out  1  low RAM write enable
ram_q  in  8  low RAM read data
text_address  out  TEXT_BITS  text RAM address
text_we  out  1  text RAM write enable
text_q  in  8  text RAM read data
bios_address  out  BIOS_BITS  BIOS address
bios_we  out  1  BIOS write enable
bios_q  in  8  BIOS read data
mem_data  out  8  registered write data to all memories
bank  out  BANK_W  current bank register

Behaviour:
- Reset (sync, reset=1 at posedge):
  - state IDLE; cpu_ready=0; cpu_in=8'hFF
  - all *_we=0; bank=0; addresses=0; mem_data=0
- Decode, priority order, on cpu_address[19:0]; bits above 19 ignored (1M wrap):
  - RAM: addr < 2^RAM_BITS.
  - TEXT: addr[19:TEXT_BITS]==TEXT_BASE[19:TEXT_BITS].
  - WIN: addr[19:16]==4'hA and videomode==2; maps to ram_address={ones above BANK_W+16, bank, addr[15:0]}.
  - BIOS: addr[19:BIOS_BITS]==BIOS_BASE[19:BIOS_BITS].
  - Otherwise UNMAPPED.
- States: IDLE, WAIT, DONE.
- IDLE: on cpu_req:
  - Latch the region.
  - Drive the region's address register (other regions' addresses hold).
  - Latch mem_data=cpu_out.
  - If cpu_we, assert that region's *_we for exactly the next cycle.
  - Load counter with region latency (writes and UNMAPPED: 0); go to WAIT.
- WAIT:
  - Counter decrements each cycle; at 0 go to DONE.
  - Write pulse occurs in the first WAIT cycle.
- DONE:
  - Reads: cpu_in <= region q (UNMAPPED: 8'hFF).
  - Writes: cpu_in unchanged.
  - cpu_ready=1 for this cycle; return to IDLE.
- Latency, request to cpu_ready: 2+WAIT_x cycles for reads; 2 cycles for writes and UNMAPPED.
- cpu_req while not IDLE is ignored; no queueing.
- UNMAPPED write: no *_we asserted; still completes.
- Window with videomode!=2: decodes UNMAPPED, reads 8'hFF.
- bank_we: bank <= bank_data next cycle, in any state.
  - An in-flight access keeps the address latched at request time.
  - A new bank applies to requests sampled after the update.
- videomode is sampled only at request time.
- Reset mid-access:
  - aborts the access; no cpu_ready for it
  - *_we cleared the same edge
  - bank cleared
- cpu_ready and *_we are never high in the same cycle for the same request.

Optional Feature:
MEM_ROUTER_BIOS_WP_EN:
- Defined: BIOS is write-protected.
  - bios_we held 0.
  - BIOS writes complete normally (cpu_ready after 2 cycles) with no effect.
- Undefined: BIOS writes assert bios_we like any other region (shadow-RAM use).

Test Plan:
- Reset then idle -> cpu_in=FF, cpu_ready=0, all we=0, bank=0.
- Write 8'h5A to 0x01234, read it back (WAIT_RAM=1) -> ram_we one cycle at 0x01234; read cpu_ready 3 cycles after req, cpu_in=5A.
- videomode=2, bank_we bank=3, write 8'hC3 to 0xA0010 -> ram_address=0x30010, ram_we pulse.
  - Same write with videomode=0 -> no we; read returns FF in 2 cycles.
- Write 8'h41 to 0xB8002, read it back -> text_address=0x0002, text_we pulse, cpu_in=41.
  - Read 0xFFFF0 -> bios_address=0x7FF0, cpu_in=bios_q.
- Write to 0xF8000 -> bios_we=1 without MEM_ROUTER_BIOS_WP_EN, bios_we=0 with it; both give cpu_ready after 2 cycles.
- Assert reset in the WAIT state of a read -> no cpu_ready, cpu_in=FF, bank=0; extra cpu_req issued while busy -> ignored, single cpu_ready.
